eta_poly_pack: RTL

Streaming BitPack encoder for the secret vectors s1 (L polys) and s2 (K polys) produced by secret-vector sampling (FIPS 204 Algorithm 33). It serves as the write-side counterpart that serialises the sampled short polynomials into the secret-key byte encoding. Each coefficient c in [-ETA, ETA] is stored as the b-bit field ETA - c, where b = 3 for ETA=2 and b = 4 for ETA=4. The fields are concatenated LSB-first and emitted as DATA_OUT_BITS-wide words over a valid/ready stream. The block sits between the sampler and the key-encoding byte sink.

---
 rtl/eta_poly_pack.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/eta_poly_pack.sv
// Streaming BitPack encoder for the s1||s2 secret polynomials: each coefficient c becomes the
// b-bit field ETA - c, packed LSB-first into DATA_OUT_BITS-wide valid/ready words.
module eta_poly_pack #(
    parameter int unsigned K             = 8,
    parameter int unsigned L             = 7,
    parameter int unsigned N             = 256,
    parameter int unsigned ETA           = 2,
    parameter int unsigned COEFF_WIDTH   = 4,
    parameter int unsigned DATA_OUT_BITS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [COEFF_WIDTH*N-1:0]     s1 [L],
    input  logic [COEFF_WIDTH*N-1:0]     s2 [K],
    output logic [DATA_OUT_BITS-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int unsigned B     = (ETA == 4) ? 4 : 3;
    localparam int unsigned GW    = 8 * B;
    localparam int unsigned AW    = DATA_OUT_BITS + GW;
    localparam int unsigned GIN   = 8 * COEFF_WIDTH;
    localparam int unsigned NGRP  = N / 8;
    localparam int unsigned NPOLY = L + K;
    localparam int unsigned PW    = $clog2(NPOLY + 1);
    localparam int unsigned GIW   = $clog2(NGRP);
    localparam int unsigned CW    = $clog2(AW + 1);
    localparam int          EtaS  = int'(ETA);
    localparam logic [B-1:0]  EtaB  = B'(ETA);
    localparam logic [CW-1:0] DwCnt = CW'(DATA_OUT_BITS);
    localparam logic [CW-1:0] GwCnt = CW'(GW);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    poly_q, poly_d;
    logic [GIW-1:0]   grp_q, grp_d;
    logic             err_q, err_d;

    logic [GIN-1:0]   coefs;
    logic [GW-1:0]    fields;
    logic             bad;
    logic [COEFF_WIDTH-1:0] c;
    int               cv;
    logic             xfer, append;

    // Current group of 8 coefficients; poly_q == NPOLY (all appended) selects nothing.
    always_comb begin
        coefs = '0;
        for (int p = 0; p < L; p++) begin
            if (poly_q == PW'(p)) coefs = s1[p][grp_q*GIN +: GIN];
        end
        for (int p = 0; p < K; p++) begin
            if (poly_q == PW'(L + p)) coefs = s2[p][grp_q*GIN +: GIN];
        end
    end

    always_comb begin
        fields = '0;
        bad    = 1'b0;
        c      = '0;
        cv     = 0;
        for (int j = 0; j < 8; j++) begin
            c  = coefs[j*COEFF_WIDTH +: COEFF_WIDTH];
            cv = int'($signed(c));
            fields[j*B +: B] = EtaB - c[B-1:0];
            if (cv > EtaS || cv < -EtaS) bad = 1'b1;
        end
    end

    assign xfer   = out_valid && out_ready;
    assign append = (state_q == StRun) && (cnt_q < DwCnt) && (poly_q != PW'(NPOLY));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (xfer && out_last) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StRun) && (cnt_q >= DwCnt);
        out_last  = out_valid && (poly_q == PW'(NPOLY)) && (cnt_q == DwCnt);
        out_data  = out_valid ? acc_q[DATA_OUT_BITS-1:0] : '0;
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = err_q;
    end

    // Emit has priority over append; a stalled word freezes everything.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        poly_d = poly_q;
        grp_d  = grp_q;
        err_d  = err_q;
        if (state_q == StIdle && start) begin
            acc_d  = '0;
            cnt_d  = '0;
            poly_d = '0;
            grp_d  = '0;
            err_d  = 1'b0;
        end else if (xfer) begin
            acc_d = acc_q >> DATA_OUT_BITS;
            cnt_d = cnt_q - DwCnt;
        end else if (append) begin
            acc_d = acc_q | (AW'(fields) << cnt_q);
            cnt_d = cnt_q + GwCnt;
            err_d = err_q | bad;
            if (grp_q == GIW'(NGRP - 1)) begin
                grp_d  = '0;
                poly_d = poly_q + PW'(1);
            end else begin
                grp_d = grp_q + GIW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            poly_q <= '0;
            grp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            poly_q <= poly_d;
            grp_q  <= grp_d;
            err_q  <= err_d;
        end
    end
endmodule
